// File: rtl/user_mac_accel_if.sv
// OBI-style request/response bundle for user_mac_accel.
// The slave modport is the accelerator side; the master modport is the requester side.
interface user_mac_accel_if #(
    parameter int AddrWidth = 32,
    parameter int IdWidth   = 1
);
    logic                 req_i;
    logic                 gnt_o;
    logic                 we_i;
    logic [3:0]           be_i;
    logic [AddrWidth-1:0] addr_i;
    logic [31:0]          wdata_i;
    logic [IdWidth-1:0]   aid_i;
    logic                 rvalid_o;
    logic [31:0]          rdata_o;
    logic                 err_o;
    logic [IdWidth-1:0]   rid_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, aid_i,
        output gnt_o, rvalid_o, rdata_o, err_o, rid_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, aid_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, rid_o
    );
endinterface

// File: rtl/user_mac_accel.sv
// Memory-mapped shift-add multiply-accumulate accelerator on an OBI slave port.
// Define USER_MAC_ACCEL_IRQ_EN to add the irq_o completion pulse output.
module user_mac_accel #(
    parameter int AddrWidth = 32,
    parameter int IdWidth   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    user_mac_accel_if.slave bus
`ifdef USER_MAC_ACCEL_IRQ_EN
    ,
    output logic irq_o
`endif
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [9:0] RegCtrl   = 10'd0;
    localparam logic [9:0] RegStatus = 10'd1;
    localparam logic [9:0] RegOpa    = 10'd2;
    localparam logic [9:0] RegOpb    = 10'd3;
    localparam logic [9:0] RegResult = 10'd4;

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [31:0]          opa_q, opa_d;
    logic [31:0]          opb_q, opb_d;
    logic [31:0]          result_q, result_d;
    logic                 done_q, done_d;
    logic [31:0]          mul_a_q, mul_a_d;
    logic [31:0]          mul_b_q, mul_b_d;
    logic [31:0]          prod_q, prod_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [IdWidth-1:0]   rid_q, rid_d;
    logic                 busy;
    logic                 finishing;
    logic [31:0]          prod_step;
    logic [9:0]           word;
    logic                 unused_addr;

    // Only the 4 KB window offset is decoded; the upper address bits are don't-care.
    assign word        = bus.addr_i[11:2];
    assign unused_addr = ^{bus.addr_i[AddrWidth-1:12], bus.addr_i[1:0]};

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        done_d    = done_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        prod_d    = prod_q;
        rvalid_d  = bus.req_i;
        rid_d     = bus.req_i ? bus.aid_i : '0;
        rdata_d   = '0;
        err_d     = 1'b0;
        busy      = (state_q == RUN);
        finishing = busy && (cnt_q == 5'd31);
        prod_step = prod_q + (mul_b_q[0] ? mul_a_q : 32'd0);

        if (bus.req_i) begin
            case (word)
                RegCtrl: begin
                    if (bus.we_i && !busy && bus.be_i[0] && bus.wdata_i[0]) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        mul_a_d = opa_q;
                        mul_b_d = opb_q;
                        prod_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                RegStatus: begin
                    if (!bus.we_i) begin
                        rdata_d = {30'd0, done_q, busy};
                        done_d  = 1'b0;
                    end
                end
                RegOpa: begin
                    if (bus.we_i) begin
                        if (!busy) opa_d = merge_be(opa_q, bus.wdata_i, bus.be_i);
                    end else begin
                        rdata_d = opa_q;
                    end
                end
                RegOpb: begin
                    if (bus.we_i) begin
                        if (!busy) opb_d = merge_be(opb_q, bus.wdata_i, bus.be_i);
                    end else begin
                        rdata_d = opb_q;
                    end
                end
                RegResult: begin
                    if (bus.we_i) begin
                        if (!busy) result_d = '0;
                    end else begin
                        rdata_d = result_q;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end

        // Completion comes last so a same-cycle STATUS read cannot swallow done.
        if (busy) begin
            prod_d  = prod_step;
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q + 5'd1;
            if (finishing) begin
                state_d  = IDLE;
                result_d = result_q + prod_step;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            prod_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            done_q   <= done_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            prod_q   <= prod_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rid_q    <= rid_d;
        end
    end

`ifdef USER_MAC_ACCEL_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = finishing;

    always_ff @(posedge clk_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`endif

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
    assign bus.rid_o    = rid_q;
endmodule

// File: tb/tb_user_mac_accel.sv
// Directed self-checking bench for user_mac_accel (also covers irq_o when
// USER_MAC_ACCEL_IRQ_EN is defined).
module tb_user_mac_accel;
    localparam logic [31:0] Base      = 32'h2000_0000;
    localparam logic [31:0] OffCtrl   = Base + 32'h00;
    localparam logic [31:0] OffStatus = Base + 32'h04;
    localparam logic [31:0] OffOpa    = Base + 32'h08;
    localparam logic [31:0] OffOpb    = Base + 32'h0C;
    localparam logic [31:0] OffResult = Base + 32'h10;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   irq_count;

    user_mac_accel_if #(.AddrWidth(32), .IdWidth(1)) bus_if ();

`ifdef USER_MAC_ACCEL_IRQ_EN
    logic irq;
    user_mac_accel #(.AddrWidth(32), .IdWidth(1)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus_if), .irq_o(irq));
    always @(negedge clk) if (irq === 1'b1) irq_count++;
`else
    user_mac_accel #(.AddrWidth(32), .IdWidth(1)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One granted transfer; returns the response sampled 1 ns after the next edge.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic aid,
                        output logic [31:0] rdata, output logic err, output logic rvalid,
                        output logic rid);
        bus_if.req_i   = 1'b1;
        bus_if.we_i    = we;
        bus_if.addr_i  = addr;
        bus_if.wdata_i = wdata;
        bus_if.be_i    = be;
        bus_if.aid_i   = aid;
        @(posedge clk);
        #1;
        bus_if.req_i = 1'b0;
        bus_if.we_i  = 1'b0;
        rdata  = bus_if.rdata_o;
        err    = bus_if.err_o;
        rvalid = bus_if.rvalid_o;
        rid    = bus_if.rid_o;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        logic e, v, r;
        xfer(1'b0, addr, 32'd0, 4'hF, 1'b0, data, e, v, r);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] d;
        logic e, v, r;
        xfer(1'b1, addr, data, be, 1'b0, d, e, v, r);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(output int busy_n, output logic [31:0] status, output bit timeout);
        logic [31:0] s;
        busy_n  = 0;
        timeout = 1'b1;
        status  = '0;
        for (int i = 0; i < 100; i++) begin
            rd(OffStatus, s);
            if (s[0]) begin
                busy_n++;
            end else begin
                status  = s;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        bus_if.req_i = 1'b0; bus_if.we_i = 1'b0; bus_if.be_i = 4'h0;
        bus_if.addr_i = '0; bus_if.wdata_i = '0; bus_if.aid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.rvalid_o, bus_if.err_o, bus_if.rid_o} !== 3'b000 || bus_if.rdata_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rvalid=%b err=%b rid=%b rdata=%h, want all zero",
                     bus_if.rvalid_o, bus_if.err_o, bus_if.rid_o, bus_if.rdata_o);
        end
`ifdef USER_MAC_ACCEL_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b want 0", irq);
        end
`endif
        bus_if.req_i = 1'b1; bus_if.addr_i = OffStatus; bus_if.aid_i = 1'b1;
        @(posedge clk);
        #1;
        bus_if.req_i = 1'b0; bus_if.aid_i = 1'b0;
        checks++;
        if (bus_if.rvalid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req_during_reset: rvalid=%b want 0", bus_if.rvalid_o);
        end
        rst = 1'b0;
        rd(OffOpa, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_opa: got %h want 0", d); end
        rd(OffResult, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", d); end
        rd(OffStatus, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_status: got %h want 0", d); end
    endtask

    task automatic test_basic_mac();
        logic [31:0] d, st;
        logic e, v, r;
        int   n;
        bit   to;
        xfer(1'b1, OffOpa, 32'd3, 4'hF, 1'b1, d, e, v, r);
        checks++;
        if ({v, e, r} !== 3'b101 || d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL write_response: rvalid=%b err=%b rid=%b rdata=%h want 1,0,1,0", v, e, r, d);
        end
        wr(OffOpb, 32'd5, 4'hF);
        wr(OffCtrl, 32'd1, 4'hF);
        wait_done(n, st, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: done never seen"); end
        checks++;
        if (n !== 32) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d want 32", n); end
        checks++;
        if (st !== 32'h2) begin errors++; $display("[TB] FAIL basic_status: got %h want 2", st); end
        rd(OffResult, d);
        checks++;
        if (d !== 32'd15) begin errors++; $display("[TB] FAIL basic_result: got %0d want 15", d); end
        rd(OffStatus, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL done_clear_on_read: got %h want 0", d); end
    endtask

    task automatic test_accumulate();
        logic [31:0] d, st;
        int   n;
        bit   to;
        wr(OffOpa, 32'd7, 4'hF);
        wr(OffOpb, 32'd6, 4'hF);
        wr(OffCtrl, 32'd1, 4'hF);
        wait_done(n, st, to);
        rd(OffResult, d);
        checks++;
        if (to !== 1'b0 || d !== 32'd57) begin
            errors++;
            $display("[TB] FAIL accumulate_result: got %0d (timeout=%b) want 57", d, to);
        end
        wr(OffResult, 32'h1234_5678, 4'hF);
        rd(OffResult, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL result_clear: got %h want 0", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d, st;
        int   n;
        bit   to;
        wr(OffOpa, 32'hFFFF_FFFF, 4'hF);
        wr(OffOpb, 32'd2, 4'hF);
        wr(OffCtrl, 32'd1, 4'hF);
        wait_done(n, st, to);
        rd(OffResult, d);
        checks++;
        if (to !== 1'b0 || d !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL wrap_result: got %h (timeout=%b) want fffffffe", d, to);
        end
        rd(OffOpa, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL opa_readback: got %h want ffffffff", d); end
    endtask

    task automatic test_error_response();
        bus_if.req_i = 1'b1; bus_if.we_i = 1'b0; bus_if.addr_i = Base + 32'h100;
        bus_if.aid_i = 1'b1; bus_if.be_i = 4'hF;
        #1;
        checks++;
        if (bus_if.gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL gnt_comb: got %b want 1", bus_if.gnt_o); end
        @(posedge clk);
        #1;
        bus_if.req_i = 1'b0; bus_if.aid_i = 1'b0;
        checks++;
        if ({bus_if.rvalid_o, bus_if.err_o, bus_if.rid_o} !== 3'b111 || bus_if.rdata_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL err_response: rvalid=%b err=%b rid=%b rdata=%h want 1,1,1,0",
                     bus_if.rvalid_o, bus_if.err_o, bus_if.rid_o, bus_if.rdata_o);
        end
        #1;
        checks++;
        if (bus_if.gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL gnt_idle: got %b want 0", bus_if.gnt_o); end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL rvalid_pulse: got %b want 0", bus_if.rvalid_o); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] d;
        wr(OffOpa, 32'd0, 4'hF);
        wr(OffOpa, 32'h1122_3344, 4'b0101);
        rd(OffOpa, d);
        checks++;
        if (d !== 32'h0022_0044) begin errors++; $display("[TB] FAIL opa_byte_en: got %h want 00220044", d); end
        wr(OffCtrl, 32'd1, 4'b1110);
        rd(OffStatus, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL start_needs_be0: status %h want 0", d); end
        wr(OffCtrl, 32'd2, 4'hF);
        rd(OffStatus, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL start_needs_bit0: status %h want 0", d); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d, st;
        int   n;
        bit   to;
        wr(OffResult, 32'd0, 4'hF);
        wr(OffOpa, 32'd2, 4'hF);
        wr(OffOpb, 32'd3, 4'hF);
        wr(OffCtrl, 32'd1, 4'hF);
        idle_cycles(9);
        wr(OffCtrl, 32'd1, 4'hF);
        wr(OffOpa, 32'd100, 4'hF);
        wait_done(n, st, to);
        checks++;
        if (to !== 1'b0 || n !== 21) begin
            errors++;
            $display("[TB] FAIL busy_restart: remaining busy %0d (timeout=%b) want 21", n, to);
        end
        rd(OffResult, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("[TB] FAIL busy_result: got %0d want 6", d); end
        rd(OffOpa, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("[TB] FAIL busy_opa: got %0d want 2", d); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int   irq_before;
        wr(OffResult, 32'd0, 4'hF);
        wr(OffOpa, 32'd5, 4'hF);
        wr(OffOpb, 32'd5, 4'hF);
        wr(OffCtrl, 32'd1, 4'hF);
        irq_before = irq_count;
        idle_cycles(15);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(OffStatus, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL abort_status: got %h want 0", d); end
        idle_cycles(40);
        rd(OffStatus, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL abort_status_late: got %h want 0", d); end
        rd(OffResult, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("[TB] FAIL abort_result: got %h want 0", d); end
        checks++;
        if (irq_count !== irq_before) begin
            errors++;
            $display("[TB] FAIL abort_irq: pulses %0d want %0d", irq_count, irq_before);
        end
    endtask

    task automatic test_irq();
`ifdef USER_MAC_ACCEL_IRQ_EN
        checks++;
        if (irq_count !== 4) begin errors++; $display("[TB] FAIL irq_pulses: got %0d want 4", irq_count); end
`endif
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        irq_count = 0;
        rst       = 1'b1;
        test_reset();
        test_basic_mac();
        test_accumulate();
        test_wrap();
        test_error_response();
        test_byte_enables();
        test_busy_ignore();
        test_reset_abort();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/user_mac_accel.md
USER_MAC_ACCEL -- requirements
Module: user_mac_accel

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: OBI address width.
REQ-002 SHALL have parameter IdWidth, default 1: OBI transaction ID width.
REQ-003 SHALL have port clk_i  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i  input  1: synchronous, active-high reset.
REQ-005 SHALL have port req_i  input  1: OBI request valid.
REQ-006 SHALL have port gnt_o  output  1: OBI grant.
REQ-007 SHALL have port we_i  input  1: 1 = write, 0 = read.
REQ-008 SHALL have port be_i  input  4: byte enables.
REQ-009 SHALL have port addr_i  input  AddrWidth: byte address; only addr_i[11:2] decoded (4 KB window at 0x2000_0000).
REQ-010 SHALL have port wdata_i  input  32: write data.
REQ-011 SHALL have port aid_i  input  IdWidth: request ID.
REQ-012 SHALL have port rvalid_o  output  1: response valid.
REQ-013 SHALL have port rdata_o  output  32: read data.
REQ-014 SHALL have port err_o  output  1: response error.
REQ-015 SHALL have port rid_o  output  IdWidth: response ID.

Function
REQ-016 SHALL drive gnt_o = req_i combinationally (no backpressure).
REQ-017 SHALL assert rvalid_o exactly one cycle after each granted request, with rid_o = aid_i of that request, for reads and writes alike.
REQ-018 SHALL decode word offsets: 0x00 CTRL (W: bit0 start), 0x04 STATUS (R: bit0 busy, bit1 done), 0x08 OPA (RW), 0x0C OPB (RW), 0x10 RESULT (R; any write clears to 0).
REQ-019 SHALL, for any other offset, return err_o=1 and rdata_o=0 with no state change; rdata_o SHALL be 0 for all writes and for CTRL reads.
REQ-020 SHALL apply writes to OPA/OPB per byte per be_i; CTRL start requires be_i[0]=1 and wdata_i[0]=1.
REQ-021 SHALL implement FSM IDLE -> RUN on start accepted in IDLE; RUN -> IDLE after exactly 32 RUN cycles.
REQ-022 SHALL in RUN compute OPA*OPB by shift-add, one multiplier bit per cycle (LSB first), into a 32-bit partial product (modulo 2^32).
REQ-023 SHALL in the 32nd RUN cycle update RESULT <= RESULT + product (modulo 2^32) and set done the following cycle.
REQ-024 SHALL report busy=1 for exactly the 32 cycles following the start write's grant cycle.
REQ-025 SHALL ignore (no error, normal response) start, OPA/OPB writes and RESULT-clear writes while busy.
REQ-026 SHALL clear done on a start accepted in IDLE and on any STATUS read (read returns pre-clear value).
REQ-027 SHALL latch OPA/OPB into internal working registers at start so that register readback is unaffected by the computation.

Reset
REQ-028 SHALL on rst_i=1 set FSM to IDLE, OPA=OPB=RESULT=0, busy=done=0, rvalid_o=0, err_o=0, rdata_o=0, rid_o=0.
REQ-029 SHALL abort an in-progress computation on reset without updating RESULT; a request presented during reset SHALL get no response.

Configuration
REQ-030 SHALL, when USER_MAC_ACCEL_IRQ_EN is defined, add output port irq_o (1 bit, reset 0) pulsing high for exactly one cycle in the cycle done becomes 1.
REQ-031 SHALL, when USER_MAC_ACCEL_IRQ_EN is undefined, omit irq_o entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: OPA=3, OPB=5, start, poll STATUS -> busy for 32 cycles, then STATUS=0x2, RESULT=15.
REQ-033 SHALL cover: follow with OPA=7, OPB=6, start -> RESULT=57; write RESULT -> RESULT reads 0.
REQ-034 SHALL cover: OPA=0xFFFF_FFFF, OPB=2 from RESULT=0 -> RESULT=0xFFFF_FFFE (wrap).
REQ-035 SHALL cover: read offset 0x100 with aid_i=1 -> next cycle rvalid_o=1, err_o=1, rdata_o=0, rid_o=1.
REQ-036 SHALL cover: second start and OPA write at cycle 10 of RUN -> ignored; RESULT and OPA unchanged by them.
REQ-037 SHALL cover: rst_i at cycle 16 of RUN -> STATUS=0, RESULT=0, no irq_o pulse.
